// File: rtl/comparator_checker.sv
// comparator_checker: scores a 2-bit magnitude comparator's {A>B, A==B, A<B}
// outputs against the expected result, counting samples, errors and input coverage.
module comparator_checker #(
    parameter int unsigned CNT_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a1,
    input  logic             a2,
    input  logic             b1,
    input  logic             b2,
    input  logic             f1,
    input  logic             f2,
    input  logic             f3,
    output logic             mismatch,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      coverage,
    output logic             busy,
    output logic             done,
    output logic             fail
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StHalt} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_smp_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [15:0]      r_coverage;
    logic             r_mismatch;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;

    logic [1:0]       w_a;
    logic [1:0]       w_b;
    logic [2:0]       w_exp;
    logic [2:0]       w_act;
    logic             w_miscompare;
    logic             w_accept;
    logic [3:0]       w_idx;
    logic [15:0]      w_cov_next;
    logic             w_smp_sat;
    logic             w_err_sat;

    assign w_a          = {a1, a2};
    assign w_b          = {b1, b2};
    assign w_exp        = {(w_a > w_b), (w_a == w_b), (w_a < w_b)};
    assign w_act        = {f1, f2, f3};
    // Full-vector compare also flags non-one-hot DUT outputs
    assign w_miscompare = (w_act != w_exp);
    // start wins over a coincident sample
    assign w_accept     = (r_state == StRun) && sample_valid && !start;
    assign w_idx        = {a1, a2, b1, b2};
    assign w_cov_next   = r_coverage | (16'h0001 << w_idx);
    assign w_smp_sat    = (r_smp_cnt == {CNT_W{1'b1}});
    assign w_err_sat    = (r_err_cnt == {CNT_W{1'b1}});

    // Control FSM with counters, coverage and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_smp_cnt  <= '0;
            r_err_cnt  <= '0;
            r_coverage <= '0;
            r_mismatch <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            if (start) begin
                r_state    <= StRun;
                r_smp_cnt  <= '0;
                r_err_cnt  <= '0;
                r_coverage <= '0;
                r_fail     <= 1'b0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else if (w_accept) begin
                r_coverage <= w_cov_next;
                if (!w_smp_sat) begin
                    r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                end
                if (w_miscompare) begin
                    r_mismatch <= 1'b1;
                    r_fail     <= 1'b1;
                    if (!w_err_sat) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end
                // Halting on error takes precedence over completing coverage
                if (w_miscompare && STOP_ON_ERR) begin
                    r_state <= StHalt;
                    r_busy  <= 1'b0;
                end else if (w_cov_next == 16'hFFFF) begin
                    r_state <= StDone;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign mismatch = r_mismatch;
    assign smp_cnt  = r_smp_cnt;
    assign err_cnt  = r_err_cnt;
    assign coverage = r_coverage;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;

endmodule
